// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the RV32I instruction fetch slice: data width, default
// reset PC, fetch FSM encoding and PC arithmetic helper.
package instruction_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_BOOT  = 2'd0,
    IF_RUN   = 2'd1,
    IF_FLUSH = 2'd2
  } if_state_e;

  // Sequential PC; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_add4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// Synchronous fetch buffer: push/pop/flush with a combinational head read from
// storage. Storage resets to RST_VAL so the head is defined straight out of reset.
module instruction_fetch_fifo #(
  parameter int               DEPTH   = 2,
  parameter int               WIDTH   = 64,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the head slot, so a push is still accepted when full.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && (!full_o || do_pop) && !flush_i;

  // Pointer and occupancy next-state; flush empties the buffer.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      else         wr_ptr_d = wr_ptr_q;
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      else         rd_ptr_d = rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RST_VAL;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the PC, issues credit-limited word fetches, buffers responses
// and hands {inst, pc} to decode. Optional perf counters under IF_PERF_CNT_EN.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if_state_e         state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     discard_q, discard_d;
  logic [CW-1:0]     inflight_net, discard_net;
  logic [CW:0]       credit_used;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [2*XLEN-1:0] fifo_head;
  logic              fire;

  assign fire         = imem_req && imem_gnt;
  assign imem_addr    = pc_q;
  // Outstanding responses still owed after this cycle's response, if any.
  assign inflight_net = imem_rvalid ? (inflight_q - CW'(1)) : inflight_q;
  assign discard_net  = (imem_rvalid && (discard_q != '0)) ? (discard_q - CW'(1)) : discard_q;
  assign credit_used  = {1'b0, fifo_count} + {1'b0, inflight_q};

  assign fifo_pop    = id_valid && id_ready;
  assign fifo_push   = (state_q == IF_RUN) && imem_rvalid && !redirect_valid
                       && (!fifo_full || fifo_pop);
  assign id_valid    = !fifo_empty;
  assign id_inst     = fifo_head[2*XLEN-1:XLEN];
  assign id_pc       = fifo_head[XLEN-1:0];
  assign id_pc_plus4 = pc_add4(id_pc);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IF_BOOT;
    else     state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IF_BOOT: state_d = IF_RUN;
      IF_RUN: begin
        if (redirect_valid && (inflight_net != '0)) state_d = IF_FLUSH;
        else                                        state_d = IF_RUN;
      end
      IF_FLUSH: begin
        if (discard_net == '0) state_d = IF_RUN;
        else                   state_d = IF_FLUSH;
      end
      default: state_d = IF_BOOT;
    endcase
  end

  // FSM output: fetch only while running, unredirected and within buffer credit.
  always_comb begin
    if ((state_q == IF_RUN) && !redirect_valid && (credit_used < (CW+1)'(FIFO_DEPTH)))
      imem_req = 1'b1;
    else
      imem_req = 1'b0;
  end

  // PC, response PC and outstanding-request bookkeeping.
  always_comb begin
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    if (redirect_valid) begin
      pc_d      = redirect_pc;
      resp_pc_d = redirect_pc;
    end else begin
      if (fire)      pc_d      = pc_add4(pc_q);
      else           pc_d      = pc_q;
      if (fifo_push) resp_pc_d = pc_add4(resp_pc_q);
      else           resp_pc_d = resp_pc_q;
    end
    if (fire && !imem_rvalid)      inflight_d = inflight_q + CW'(1);
    else if (!fire && imem_rvalid) inflight_d = inflight_q - CW'(1);
    else                           inflight_d = inflight_q;
    if ((state_q == IF_RUN) && redirect_valid) discard_d = inflight_net;
    else if (state_q == IF_FLUSH)              discard_d = discard_net;
    else                                       discard_d = discard_q;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  instruction_fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .WIDTH   (2*XLEN),
    .RST_VAL ({32'h0000_0000, RESET_PC})
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (fifo_push),
    .data_i  ({imem_rdata, resp_pc_q}),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_stall_q;

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;

  // Handshake and decode-starvation counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= 32'd0;
      perf_stall_q   <= 32'd0;
    end else begin
      if (fifo_pop) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (id_ready && !id_valid && (state_q != IF_BOOT)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized bench for instruction_fetch: a transaction-level model (outstanding-request
// queue, buffered count, expected PC streams) checks every cycle; a second instance checks PC wrap.
module tb_instruction_fetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;

  logic        redirect_valid, imem_req, imem_gnt, imem_rvalid, id_valid, id_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, id_inst, id_pc, id_pc_plus4;

  logic        b_redirect_valid, b_imem_req, b_imem_gnt, b_imem_rvalid, b_id_valid, b_id_ready;
  logic [31:0] b_redirect_pc, b_imem_addr, b_imem_rdata, b_id_inst, b_id_pc, b_id_pc_plus4;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_stall, b_perf_fetched, b_perf_stall;
  int unsigned m_fetched, m_stall;
`endif

  int          n_vec = 0;
  int          n_err = 0;

  logic [31:0] memq[$];
  bit          disc[$];
  int          buffered;
  logic [31:0] fetch_pc, expect_pc;
  bit          booted;

  bit          b_pend;
  logic [31:0] b_pend_addr, b_expect;
  int          b_seen = 0;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
    .id_ready(id_ready), .id_inst(id_inst), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_wrap (
    .clk(clk), .rst(rst), .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .imem_req(b_imem_req), .imem_addr(b_imem_addr), .imem_gnt(b_imem_gnt),
    .imem_rvalid(b_imem_rvalid), .imem_rdata(b_imem_rdata), .id_valid(b_id_valid),
    .id_ready(b_id_ready), .id_inst(b_id_inst), .id_pc(b_id_pc), .id_pc_plus4(b_id_pc_plus4)
`ifdef IF_PERF_CNT_EN
    , .perf_fetched(b_perf_fetched), .perf_stall(b_perf_stall)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memfunc(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    memq.delete();
    disc.delete();
    buffered  = 0;
    fetch_pc  = 32'h0000_0000;
    expect_pc = 32'h0000_0000;
    booted    = 1'b0;
    b_pend    = 1'b0;
    b_expect  = 32'hFFFF_FFF8;
`ifdef IF_PERF_CNT_EN
    m_fetched = 0;
    m_stall   = 0;
`endif
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance the model, wait for next edge.
  task automatic step(input int p_gnt, input int p_rv, input int p_rdy, input int p_redir,
                      input logic [31:0] tgt);
    logic [31:0] r;
    bit disc_any, exp_req, hs, d;
    r              = $urandom;
    imem_gnt       = ($urandom_range(99) < p_gnt);
    imem_rvalid    = (memq.size() > 0) && ($urandom_range(99) < p_rv);
    imem_rdata     = imem_rvalid ? memfunc(memq[0]) : r;
    id_ready       = ($urandom_range(99) < p_rdy);
    redirect_valid = ($urandom_range(99) < p_redir);
    if (tgt != 32'h0000_0001)          redirect_pc = tgt;
    else if ($urandom_range(3) == 0)   redirect_pc = 32'hFFFF_FFF8;
    else                               redirect_pc = r & 32'h0000_FFFC;
    b_imem_gnt       = 1'b1;
    b_id_ready       = 1'b1;
    b_redirect_valid = 1'b0;
    b_redirect_pc    = 32'h0000_0000;
    b_imem_rvalid    = b_pend;
    b_imem_rdata     = memfunc(b_pend_addr);

    disc_any = 1'b0;
    foreach (disc[i]) if (disc[i]) disc_any = 1'b1;
    exp_req = booted && !redirect_valid && !disc_any && ((disc.size() + buffered) < DEPTH);

    @(negedge clk);
    if (!rst) begin
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      chk("imem_addr", imem_addr, fetch_pc);
      chk("id_valid", 32'(id_valid), 32'(buffered > 0));
      if (buffered > 0) begin
        chk("id_pc", id_pc, expect_pc);
        chk("id_inst", id_inst, memfunc(expect_pc));
        chk("id_pc_plus4", id_pc_plus4, expect_pc + 32'd4);
      end
`ifdef IF_PERF_CNT_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_stall", perf_stall, m_stall);
`endif
      if (b_id_valid) begin
        chk("wrap_id_pc", b_id_pc, b_expect);
        chk("wrap_id_inst", b_id_inst, memfunc(b_expect));
        chk("wrap_id_pc_plus4", b_id_pc_plus4, b_expect + 32'd4);
        b_expect = b_expect + 32'd4;
        b_seen++;
      end
    end

    if (rst) begin
      model_reset();
    end else begin
      hs = (buffered > 0) && id_ready;
      if (hs) begin
        buffered--;
        expect_pc = expect_pc + 32'd4;
      end
`ifdef IF_PERF_CNT_EN
      if (hs) m_fetched++;
      if (id_ready && (buffered == 0) && !hs && booted) m_stall++;
`endif
      if (imem_rvalid) begin
        d = disc.pop_front();
        void'(memq.pop_front());
        if (!d && !redirect_valid) buffered++;
      end
      if (exp_req && imem_gnt) begin
        memq.push_back(imem_addr);
        disc.push_back(1'b0);
        fetch_pc = fetch_pc + 32'd4;
      end
      if (redirect_valid) begin
        foreach (disc[i]) disc[i] = 1'b1;
        buffered  = 0;
        fetch_pc  = redirect_pc;
        expect_pc = redirect_pc;
      end
      booted      = 1'b1;
      b_pend      = b_imem_req;
      b_pend_addr = b_imem_addr;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 32'h0000_0000);
    step(0, 0, 0, 0, 32'h0000_0000);

    // Reset values with rst still asserted.
    @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'h0000_0000);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_inst", id_inst, 32'h0000_0000);
    chk("rst_id_pc", id_pc, 32'h0000_0000);
    chk("rst_wrap_id_pc", b_id_pc, 32'hFFFF_FFF8);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming with a 1-cycle memory and an always-ready decode.
    for (int i = 0; i < 20; i++) step(100, 100, 100, 0, 32'h0000_0001);
    chk("wrap_stream_seen", 32'(b_seen >= 3), 32'd1);

    // Decode back-pressure, then resume.
    for (int i = 0; i < 8; i++)  step(100, 100, 0, 0, 32'h0000_0001);
    for (int i = 0; i < 10; i++) step(100, 100, 100, 0, 32'h0000_0001);

    // Two requests in flight, then redirect to 0x100.
    for (int i = 0; i < 4; i++)  step(100, 0, 100, 0, 32'h0000_0001);
    step(100, 0, 100, 100, 32'h0000_0100);
    for (int i = 0; i < 12; i++) step(100, 100, 100, 0, 32'h0000_0001);

    // Redirect coinciding with a response and a decode handshake.
    for (int i = 0; i < 6; i++)  step(100, 100, 100, 0, 32'h0000_0001);
    step(100, 100, 100, 100, 32'h0000_0200);
    for (int i = 0; i < 10; i++) step(100, 100, 100, 0, 32'h0000_0001);

    // Randomized traffic with mixed rates.
    for (int blk = 0; blk < 15; blk++) begin
      int pg, pv, pr;
      pg = $urandom_range(20, 100);
      pv = $urandom_range(20, 100);
      pr = $urandom_range(10, 100);
      for (int i = 0; i < 100; i++) step(pg, pv, pr, 4, 32'h0000_0001);
    end

    // Mid-operation reset, then more traffic.
    rst = 1'b1;
    step(60, 60, 60, 0, 32'h0000_0001);
    rst = 1'b0;
    for (int i = 0; i < 300; i++) step(70, 60, 70, 3, 32'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
